// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, drives the
// instruction-memory address and registers the fetched word, its PC and
// PC+4 into the IF/ID pipeline register for decode.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d_next;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pcd_q;
    logic [XLEN-1:0] pc4d_q;
    logic            valid_q;

    // Sequential PC increment wraps modulo 2^XLEN; redirect target is
    // forced word-aligned by masking the two low bits.
    always_comb begin
        pc_plus4_f = pc_q + FOUR;
        pc_d_next  = pc_src_e ? (pc_target_e & ALIGN_MASK) : pc_plus4_f;
    end

    // PC register: reset, then redirect (beats stall), then stall, then +4.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (pc_src_e || !stall_f) begin
            pc_q <= pc_d_next;
        end
    end

    // IF/ID register: reset/flush insert a bubble, stall holds, else capture.
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pc4d_q  <= '0;
            valid_q <= 1'b0;
        end else if (!stall_d) begin
            instr_q <= imem_rdata;
            pcd_q   <= pc_q;
            pc4d_q  <= pc_plus4_f;
            valid_q <= 1'b1;
        end
    end

    assign imem_addr  = pc_q;
    assign instr_d    = instr_q;
    assign pc_d       = pcd_q;
    assign pc_plus4_d = pc4d_q;
    assign valid_d    = valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the RISC-V pipeline. The block holds the program counter and drives the instruction-memory address. It registers the fetched instruction, its PC and PC+4 into the decode stage, where the instruction's opcode/funct3/funct7 fields feed the control path. The block consumes the control path's resolved `pc_src` and the branch/jump target from execute. It also honours stall and flush requests from the hazard unit.

## Interface
- `XLEN`, default 32: address and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0013: instruction inserted on reset or flush (`addi x0,x0,0`).

Reset is synchronous and active-high.

- `clk` input 1: single clock. All registers update on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall_f` input 1: hold the PC register.
- `stall_d` input 1: hold the IF/ID register.
- `flush_d` input 1: replace the IF/ID contents with a bubble.
- `pc_src_e` input 1: redirect taken (branch&&zero or jump) from execute.
- `pc_target_e` input XLEN: redirect target from execute.
- `imem_addr` output XLEN: instruction-memory address. Equals the current PC register `pc_f`.
- `imem_rdata` input XLEN: instruction word. Combinational read of `imem_addr`, same cycle.
- `instr_d` output XLEN: registered instruction to decode.
- `pc_d` output XLEN: registered PC of `instr_d`.
- `pc_plus4_d` output XLEN: registered `pc_d + 4`.
- `valid_d` output 1: 1 when `instr_d` is a real fetched instruction; 0 for a reset or flush bubble.

## Operation
- PC next-value:
  - `pc_next = pc_src_e ? {pc_target_e[XLEN-1:2],2'b00} : pc_f + 4`.
  - Addition is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0.
  - Target bits [1:0] are discarded.
- PC register priority, highest first:
  - `rst`: `pc_f <= RESET_PC`.
  - `pc_src_e`: `pc_f <= pc_next`. A redirect wins over `stall_f`.
  - `stall_f`: hold.
  - Otherwise: `pc_f <= pc_f + 4`.
- IF/ID register priority, highest first:
  - `rst` or `flush_d`: load `instr_d=NOP_INSTR`, `pc_d=0`, `pc_plus4_d=0`, `valid_d=0`.
  - `stall_d`: hold all four fields.
  - Otherwise: load `instr_d=imem_rdata`, `pc_d=pc_f`, `pc_plus4_d=pc_f+4`, `valid_d=1`.
- `flush_d` together with `stall_d`: flush wins.
- `stall_f` together with `flush_d` and no redirect: the PC holds and the bubble is loaded. The held instruction is refetched the next cycle.
- No internal hazard detection. The hazard unit owns all stall and flush decisions.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `pc_f = imem_addr = RESET_PC`
  - `instr_d = NOP_INSTR`
  - `pc_d = 0`, `pc_plus4_d = 0`
  - `valid_d = 0`
- `rst` asserted mid-stream overrides stall, flush and redirect in the same edge.
- Fetch latency: one cycle from `imem_addr` to `instr_d`. The instruction at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- Redirect:
  - `pc_src_e` is sampled in cycle N, so `imem_addr = target` in cycle N+1.
  - `instr_d` shows the target instruction in cycle N+2.
  - The hazard unit asserts `flush_d` in cycle N to kill the wrong-path fetch.
- Stall: with `stall_f=stall_d=1` for K cycles, `imem_addr`, `instr_d`, `pc_d` and `valid_d` are constant for K cycles. Fetch resumes from the held PC.
- Outputs are purely registered or register-derived, with no combinational input-to-output paths. The one exception is the data path from `imem_rdata` to the IF/ID register input.

## Test plan
- Reset then free-run, with memory word at addr A equal to A|32'h13:
  - `imem_addr` steps 0,4,8,12.
  - `instr_d` lags by one cycle with `pc_d` = 0,4,8.
  - `pc_plus4_d` = `pc_d`+4.
  - `valid_d` rises one cycle after reset release.
- Redirect with flush:
  - Stimulus: at PC=0x10, assert `pc_src_e=1`, `pc_target_e=0x40`, `flush_d=1` for one cycle.
  - Next cycle: `imem_addr=0x40`, `instr_d=NOP_INSTR`, `valid_d=0`.
  - Following cycle: `pc_d=0x40`, `valid_d=1`.
- Load-use stall:
  - Stimulus: at PC=0x20, assert `stall_f=stall_d=1` for 2 cycles.
  - `imem_addr` holds 0x20 and `pc_d` holds 0x1C for 2 cycles, then resumes 0x24 / 0x20.
- Simultaneous events:
  - `pc_src_e=1` with `stall_f=1`, target 0x100: PC loads 0x100.
  - `flush_d=1` with `stall_d=1`: the bubble is loaded.
- Edge values:
  - `RESET_PC=32'hFFFF_FFFC`: next `imem_addr` = 0.
  - Target 0x43: PC becomes 0x40.
- Mid-stall reset:
  - Stimulus: assert `rst` while `stall_f=stall_d=1` at PC=0x80.
  - Next cycle: PC=RESET_PC, `instr_d=NOP_INSTR`, `valid_d=0`.
